// File: rtl/keypad_key_player_pkg.sv
// Shared constants, types and key decode for the keypad key player.
// Row/column one-hot codes match the 4x3 matrix wiring seen by the scanner.
package keypad_key_player_pkg;

  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_REST = 4'd15;

  localparam logic [3:0] ROW0     = 4'b1000;
  localparam logic [3:0] ROW1     = 4'b0100;
  localparam logic [3:0] ROW2     = 4'b0010;
  localparam logic [3:0] ROW3     = 4'b0001;
  localparam logic [3:0] ROW_NONE = 4'b0000;

  localparam logic [2:0] COL_L    = 3'b100;
  localparam logic [2:0] COL_M    = 3'b010;
  localparam logic [2:0] COL_R    = 3'b001;
  localparam logic [2:0] COL_NONE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] row;
    logic [2:0] col;
  } press_t;

  // Unknown codes decode to an all-zero press, which plays as a silent rest.
  function automatic press_t decode_key(input logic [3:0] code);
    press_t p;
    p = '{row: ROW_NONE, col: COL_NONE};
    case (code)
      4'd1:     p = '{row: ROW0, col: COL_L};
      4'd2:     p = '{row: ROW0, col: COL_M};
      4'd3:     p = '{row: ROW0, col: COL_R};
      4'd4:     p = '{row: ROW1, col: COL_L};
      4'd5:     p = '{row: ROW1, col: COL_M};
      4'd6:     p = '{row: ROW1, col: COL_R};
      4'd7:     p = '{row: ROW2, col: COL_L};
      4'd8:     p = '{row: ROW2, col: COL_M};
      4'd9:     p = '{row: ROW2, col: COL_R};
      KEY_STAR: p = '{row: ROW3, col: COL_L};
      4'd0:     p = '{row: ROW3, col: COL_M};
      KEY_HASH: p = '{row: ROW3, col: COL_R};
      KEY_REST: p = '{row: ROW_NONE, col: COL_NONE};
      default:  p = '{row: ROW_NONE, col: COL_NONE};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/keypad_key_fifo.sv
// Small synchronous FIFO holding queued key codes; power-of-2 depth.
// Full is taken from the registered count, so a pop never frees room for a same-cycle push.
module keypad_key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/keypad_key_player.sv
// Key side of a 4x3 matrix keypad: replays queued key codes as timed presses,
// closing the pressed key's column whenever the scanner drives its row.
module keypad_key_player
  import keypad_key_player_pkg::*;
#(
  parameter int HOLD_CYCLES = 4000,
  parameter int GAP_CYCLES  = 2000,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] row_scan,
  output logic [2:0] col_out,
  output logic       busy,
  output logic       done_pulse
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  press_t           press, press_nxt;
  logic             done_nxt;
  logic             pop;
  logic             full, empty;
  logic [3:0]       fifo_code;

  keypad_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (key_valid),
    .din   (key_code),
    .pop   (pop),
    .dout  (fifo_code),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      press      <= '0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      press      <= press_nxt;
      done_pulse <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_nxt = press;
    done_nxt  = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          press_nxt = decode_key(fifo_code);
          cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
          state_nxt = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (cnt == '0) begin
          press_nxt = '0;
          cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
          state_nxt = ST_GAP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Combinational from row_scan so the scanner sees a zero-latency closure.
  assign col_out   = ((row_scan & press.row) != 4'b0000) ? press.col : COL_NONE;
  assign busy      = (state != ST_IDLE) || !empty;
  assign key_ready = !full;

endmodule
